// File: rtl/weight_bit_serializer_16.sv
// Bit-plane sequencer for a 16-lane bit-serial signed MAC: captures a vector,
// converts weights to sign-magnitude and issues magnitude bit-planes LSB first.
module weight_bit_serializer_16 #(
  parameter int DATA_WIDTH = 8,
  parameter int W_WIDTH    = 8,
  parameter int VEC_LENGTH = 16,
  localparam int CW        = $clog2(W_WIDTH),
  localparam int NW        = CW + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] in_act,
  input  logic [VEC_LENGTH*W_WIDTH-1:0]    in_weight,
  input  logic                             skip_zero_en,
  output logic [VEC_LENGTH*DATA_WIDTH-1:0] act_out,
  output logic [VEC_LENGTH-1:0]            sign_out,
  output logic [VEC_LENGTH-1:0]            w_bit_out,
  output logic [CW-1:0]                    column_idx,
  output logic                             mac_clear,
  output logic                             result_valid,
  output logic [NW-1:0]                    n_planes,
  output logic                             busy
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PRIME, S_RUN, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   k_q, k_d;
  logic [NW-1:0]                   cnt_q, cnt_d;
  logic [VEC_LENGTH*DATA_WIDTH-1:0] act_q;
  logic [VEC_LENGTH-1:0]           sign_q;
  logic [W_WIDTH-1:0]              mag_q [VEC_LENGTH];
  logic [W_WIDTH-1:0]              mask_q;
  logic                            skip_q;

  logic [VEC_LENGTH-1:0]           new_sign;
  logic [W_WIDTH-1:0]              new_mag [VEC_LENGTH];
  logic [W_WIDTH-1:0]              new_mask;
  logic [W_WIDTH-1:0]              wt;

  logic                            first_found, next_found;
  logic [CW-1:0]                   first_k, next_k;

  logic                            mac_clear_q, mac_clear_d;
  logic                            result_valid_q, result_valid_d;
  logic [VEC_LENGTH-1:0]           w_bit_q, w_bit_d;
  logic [VEC_LENGTH-1:0]           sign_out_q, sign_out_d;
  logic [CW-1:0]                   col_q, col_d;
  logic [NW-1:0]                   n_planes_q, n_planes_d;
  logic                            run_d;
  logic                            accept;

  // Handshake: a vector transfers on any rising edge where in_valid and
  // in_ready are both high; in_ready is only offered in IDLE and DONE.
  assign in_ready = !reset && (state_q == S_IDLE || state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    new_sign = '0;
    new_mask = '0;
    wt       = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      wt          = in_weight[j*W_WIDTH +: W_WIDTH];
      new_sign[j] = wt[W_WIDTH-1];
      new_mag[j]  = wt[W_WIDTH-1] ? (~wt + 1'b1) : wt;
      new_mask    = new_mask | new_mag[j];
    end
  end

  // Lowest set plane overall, and lowest set plane strictly above the current one.
  always_comb begin
    first_found = 1'b0;
    first_k     = '0;
    next_found  = 1'b0;
    next_k      = '0;
    for (int i = W_WIDTH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_found = 1'b1;
        first_k     = CW'(i);
      end
      if (mask_q[i] && (i > int'(k_q))) begin
        next_found = 1'b1;
        next_k     = CW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CLEAR;
      S_CLEAR: state_d = S_PRIME;
      S_PRIME: begin
        state_d = S_RUN;
        k_d     = (skip_q && first_found) ? first_k : '0;
        cnt_d   = NW'(1);
      end
      S_RUN: begin
        if (skip_q) begin
          if (next_found) begin
            k_d   = next_k;
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else if (k_q == CW'(W_WIDTH - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d   = k_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = accept ? S_CLEAR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered.
  always_comb begin
    run_d          = (state_d == S_RUN);
    mac_clear_d    = (state_d == S_CLEAR);
    result_valid_d = (state_d == S_DONE);
    sign_out_d     = run_d ? sign_q : '0;
    col_d          = run_d ? k_d : '0;
    n_planes_d     = result_valid_d ? cnt_q : n_planes_q;
    w_bit_d        = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      w_bit_d[j] = run_d & mag_q[j][k_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      cnt_q          <= '0;
      act_q          <= '0;
      sign_q         <= '0;
      mask_q         <= '0;
      skip_q         <= 1'b0;
      mac_clear_q    <= 1'b0;
      result_valid_q <= 1'b0;
      w_bit_q        <= '0;
      sign_out_q     <= '0;
      col_q          <= '0;
      n_planes_q     <= '0;
      for (int j = 0; j < VEC_LENGTH; j++) mag_q[j] <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      cnt_q          <= cnt_d;
      mac_clear_q    <= mac_clear_d;
      result_valid_q <= result_valid_d;
      w_bit_q        <= w_bit_d;
      sign_out_q     <= sign_out_d;
      col_q          <= col_d;
      n_planes_q     <= n_planes_d;
      if (accept) begin
        act_q  <= in_act;
        sign_q <= new_sign;
        mask_q <= new_mask;
        skip_q <= skip_zero_en;
        for (int j = 0; j < VEC_LENGTH; j++) mag_q[j] <= new_mag[j];
      end
    end
  end

  assign act_out      = act_q;
  assign sign_out     = sign_out_q;
  assign w_bit_out    = w_bit_q;
  assign column_idx   = col_q;
  assign mac_clear    = mac_clear_q;
  assign result_valid = result_valid_q;
  assign n_planes     = n_planes_q;

endmodule

// File: tb/tb_weight_bit_serializer_16.sv
// Self-checking bench for weight_bit_serializer_16: per-cycle output trace model
// plus a MAC accumulator that checks every job's result against the dot product.
module tb_weight_bit_serializer_16;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int VL = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           skip_zero_en = 1'b0;
  logic [VL*DW-1:0] in_act = '0;
  logic [VL*WW-1:0] in_weight = '0;
  logic           in_ready;
  logic [VL*DW-1:0] act_out;
  logic [VL-1:0]  sign_out;
  logic [VL-1:0]  w_bit_out;
  logic [2:0]     column_idx;
  logic           mac_clear;
  logic           result_valid;
  logic [3:0]     n_planes;
  logic           busy;

  weight_bit_serializer_16 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_weight(in_weight), .skip_zero_en(skip_zero_en),
    .act_out(act_out), .sign_out(sign_out), .w_bit_out(w_bit_out),
    .column_idx(column_idx), .mac_clear(mac_clear), .result_valid(result_valid),
    .n_planes(n_planes), .busy(busy)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected per-cycle output record
  typedef struct packed {
    logic              clr;
    logic              rv;
    logic              bsy;
    logic              rdy;
    logic [15:0]       w;
    logic [15:0]       s;
    logic [2:0]        col;
    logic [127:0]      act;
    logic [3:0]        n;
    logic signed [31:0] dot;
  } rec_t;

  rec_t         exp_q[$];
  logic [127:0] act_last = '0;
  logic [3:0]   n_last = '0;
  int           n_vec = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           acc_cnt = 0;
  int           rv_cnt = 0;
  int           acc_cyc = 0;
  int           rv_cyc = 0;
  int           prev_rv_cyc = 0;
  longint       mac_acc = 0;
  longint       last_result = 0;
  int           last_nz_col = -1;
  int           last_n = 0;

  task automatic check_int(input string name, input longint actual, input longint expected);
    n_vec++;
    if (actual != expected) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: the full output trace of one job, derived from the rules.
  function automatic void push_job(input logic [127:0] a, input logic [127:0] w, input logic s);
    int       mag [VL];
    logic [15:0] sg;
    logic [7:0]  m;
    int       planes[$];
    longint   dot;
    rec_t     r;
    int       wj, aj;
    sg = '0; m = '0; dot = 0;
    for (int j = 0; j < VL; j++) begin
      wj = int'($signed(w[j*WW +: WW]));
      aj = int'($signed(a[j*DW +: DW]));
      sg[j] = (wj < 0);
      mag[j] = (wj < 0) ? -wj : wj;
      for (int k = 0; k < WW; k++) if (((mag[j] >> k) & 1) == 1) m[k] = 1'b1;
      dot += longint'(aj) * longint'(wj);
    end
    if (s) begin
      for (int k = 0; k < WW; k++) if (m[k]) planes.push_back(k);
      if (planes.size() == 0) planes.push_back(0);
    end else begin
      for (int k = 0; k < WW; k++) planes.push_back(k);
    end
    r = '0; r.act = a; r.n = n_last; r.bsy = 1'b1;
    r.clr = 1'b1; exp_q.push_back(r);
    r.clr = 1'b0; exp_q.push_back(r);
    foreach (planes[p]) begin
      r.col = 3'(planes[p]);
      r.s = sg;
      for (int j = 0; j < VL; j++) r.w[j] = ((mag[j] >> planes[p]) & 1) == 1;
      exp_q.push_back(r);
    end
    r.w = '0; r.s = '0; r.col = '0;
    r.rv = 1'b1; r.rdy = 1'b1; r.n = 4'(planes.size()); r.dot = 32'(dot);
    exp_q.push_back(r);
    n_last = 4'(planes.size());
    act_last = a;
  endfunction

  // Scoreboard / compare process: one record per cycle, sampled on negedge.
  initial begin
    rec_t   rec;
    longint a;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() != 0) rec = exp_q.pop_front();
      else begin
        rec = '0; rec.rdy = 1'b1; rec.act = act_last; rec.n = n_last;
      end
      if (reset) rec.rdy = 1'b0;
      check_int("mac_clear", mac_clear, rec.clr);
      check_int("result_valid", result_valid, rec.rv);
      check_int("busy", busy, rec.bsy);
      check_int("in_ready", in_ready, rec.rdy);
      check_vec("w_bit_out", w_bit_out, rec.w);
      check_vec("sign_out", sign_out, rec.s);
      check_int("column_idx", column_idx, rec.col);
      check_vec("act_out", act_out, rec.act);
      check_int("n_planes", n_planes, rec.n);
      if (mac_clear) mac_acc = 0;
      else begin
        for (int j = 0; j < VL; j++) begin
          if (w_bit_out[j]) begin
            a = longint'($signed(act_out[j*DW +: DW]));
            if (sign_out[j]) a = -a;
            mac_acc += a * (longint'(1) << column_idx);
          end
        end
      end
      if (|w_bit_out) last_nz_col = int'(column_idx);
      if (rec.rv) begin
        check_int("mac_result", mac_acc, longint'($signed(rec.dot)));
        last_result = mac_acc;
        last_n = int'(n_planes);
        prev_rv_cyc = rv_cyc;
        rv_cyc = cyc;
        rv_cnt++;
      end
      if (reset) begin
        exp_q.delete();
        act_last = '0;
        n_last = '0;
        mac_acc = 0;
      end else if (in_valid && rec.rdy) begin
        push_job(in_act, in_weight, skip_zero_en);
        acc_cnt++;
        acc_cyc = cyc;
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [127:0] a, input logic [127:0] w, input logic s, input bit keep);
    int  start;
    bit  ok;
    in_act = a; in_weight = w; skip_zero_en = s; in_valid = 1'b1;
    start = acc_cnt; ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != start) begin ok = 1; break; end
    end
    if (!ok) check_int("accept_timeout", 0, 1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_results(input int start, input int n);
    for (int i = 0; i < 300; i++) begin
      if (rv_cnt - start >= n) break;
      @(posedge clk); #1;
    end
    if (rv_cnt - start < n) check_int("result_timeout", rv_cnt - start, n);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stimulus
  initial begin
    logic [127:0] a, w, a2, w2;
    int   start;
    logic [7:0] pm;
    bit   keep;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Skip off, act 1, weight 3
    for (int j = 0; j < VL; j++) begin a[j*8 +: 8] = 8'd1; w[j*8 +: 8] = 8'd3; end
    last_nz_col = -1; start = rv_cnt;
    send(a, w, 1'b0, 0);
    wait_results(start, 1);
    check_int("d1_latency", rv_cyc - acc_cyc, 11);
    check_int("d1_result", last_result, 48);
    check_int("d1_nplanes", last_n, 8);
    check_int("d1_last_col", last_nz_col, 1);

    // Skip on, single -128 weight
    a = rand128(); a[7:0] = 8'd5; w = '0; w[7:0] = 8'h80;
    last_nz_col = -1; start = rv_cnt;
    send(a, w, 1'b1, 0);
    wait_results(start, 1);
    check_int("d2_latency", rv_cyc - acc_cyc, 4);
    check_int("d2_result", last_result, -640);
    check_int("d2_nplanes", last_n, 1);
    check_int("d2_col", last_nz_col, 7);

    // Skip on, all-zero weights
    a = rand128(); w = '0;
    last_nz_col = -1; start = rv_cnt;
    send(a, w, 1'b1, 0);
    wait_results(start, 1);
    check_int("d3_latency", rv_cyc - acc_cyc, 4);
    check_int("d3_result", last_result, 0);
    check_int("d3_nplanes", last_n, 1);
    check_int("d3_no_wbits", last_nz_col, -1);

    // Back-to-back with in_valid held high
    a = rand128(); w = rand128(); a2 = rand128(); w2 = rand128();
    start = rv_cnt;
    send(a, w, 1'b0, 1);
    send(a2, w2, 1'b0, 0);
    wait_results(start, 2);
    check_int("b2b_spacing", rv_cyc - prev_rv_cyc, 11);

    // Reset in the middle of a job
    repeat (2) @(posedge clk);
    #1;
    start = rv_cnt;
    send(rand128(), rand128(), 1'b0, 0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check_int("rst_no_result", rv_cnt - start, 0);

    // Random vectors
    start = rv_cnt;
    for (int n = 0; n < 1000; n++) begin
      a = rand128();
      w = rand128();
      case ($urandom_range(0, 3))
        0: begin
          pm = 8'($urandom_range(0, 255));
          for (int j = 0; j < VL; j++) w[j*8 +: 8] = w[j*8 +: 8] & pm;
        end
        1: if ($urandom_range(0, 3) == 0) w = '0;
        default: ;
      endcase
      keep = ($urandom_range(0, 3) == 0) && (n != 999);
      send(a, w, 1'($urandom_range(0, 1)), keep);
      if (!keep) begin
        in_act = rand128();
        in_weight = rand128();
        skip_zero_en = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    wait_results(start, 1000);
    check_int("rand_job_count", rv_cnt - start, 1000);
    repeat (3) @(posedge clk);
    #1;

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
